// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
// Module : qu_uop (package)
// Brief  : Shared micro-op types for result broadcast and retire.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qu_uop;

  localparam int c_NUM_FU = 4;
  localparam int c_ROB_AW = 4;

  typedef logic [31:0] phy_rf_data_t;

  typedef struct packed {
    logic                busy;
    logic [c_ROB_AW-1:0] rob_addr;
    logic [5:0]          opcode;
    logic [5:0]          dst_preg;
  } res_st_cell_t;

  typedef struct packed {
    phy_rf_data_t value;
    logic         comp_result;
    res_st_cell_t op;
  } fu_result_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } cdb_state_t;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
// ============================================================================
// Module : cdb_arbiter_if
// Brief  : FU request side and retire side signals of the result arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cdb_arbiter_if
  import qu_uop::*;
#(
  parameter int NUM_FU = c_NUM_FU
) ();

  logic [NUM_FU-1:0]              fu_valid;
  fu_result_t [NUM_FU-1:0]        fu_result;
  logic [NUM_FU-1:0]              fu_ready;
  logic                           retire_ready;
  logic                           flush;
  phy_rf_data_t                   value_out;
  logic                           comp_result_out;
  res_st_cell_t                   op_out;
  logic [15:0]                    conflict_cnt;

  // Arbiter side
  modport slave (
    input  fu_valid, fu_result, retire_ready, flush,
    output fu_ready, value_out, comp_result_out, op_out, conflict_cnt
  );

  // Environment side (FUs + retire stage)
  modport master (
    output fu_valid, fu_result, retire_ready, flush,
    input  fu_ready, value_out, comp_result_out, op_out, conflict_cnt
  );

endinterface

`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first set req at or after ptr.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_FU = 4,
  parameter int PW     = 2
) (
  input  wire  [NUM_FU-1:0] req,
  input  wire  [PW-1:0]     ptr,
  output logic [NUM_FU-1:0] gnt
);

  logic          w_found;
  logic [PW:0]   w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      // ptr + k never reaches 2*NUM_FU, so one conditional subtract wraps it
      w_idx = {1'b0, ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NUM_FU)) begin
        w_idx = w_idx - (PW+1)'(NUM_FU);
      end
      if (!w_found && req[w_idx[PW-1:0]]) begin
        gnt[w_idx[PW-1:0]] = 1'b1;
        w_found            = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module : cdb_arbiter
// Brief  : Round-robin common-data-bus arbiter with a one-entry output register.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
  import qu_uop::*;
#(
  parameter int NUM_FU = c_NUM_FU
) (
  input wire           clk,
  input wire           rst,
  cdb_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_FU);

  cdb_state_t        r_state;
  logic [PW-1:0]     r_ptr;
  phy_rf_data_t      r_value;
  logic              r_comp;
  res_st_cell_t      r_op;
  logic [15:0]       r_cnt;

  logic [NUM_FU-1:0] w_gnt;
  logic [NUM_FU-1:0] w_ready;
  logic [PW-1:0]     w_gnt_idx;
  logic [PW-1:0]     w_ptr_nxt;
  logic              w_free;
  logic              w_grant_en;
  logic              w_grant;
  logic              w_conflict;
  fu_result_t        w_sel;
  res_st_cell_t      w_op_out;

  rr_arbiter #(
    .NUM_FU (NUM_FU),
    .PW     (PW)
  ) u_rr (
    .req (bus.fu_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  assign w_free     = (r_state == ST_IDLE) || bus.retire_ready;
  // rst gates the grant so fu_ready is low for the whole reset interval
  assign w_grant_en = w_free && !bus.flush && rst;
  assign w_ready    = w_grant_en ? w_gnt : '0;
  assign w_grant    = |w_ready;
  assign w_conflict = |(bus.fu_valid & ~w_ready);

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx = PW'(i);
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == PW'(NUM_FU - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_sel     = bus.fu_result[w_gnt_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_value <= '0;
      r_comp  <= 1'b0;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_conflict && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (bus.flush) begin
        r_state <= ST_IDLE;
      end else if (w_grant) begin
        r_state <= ST_SEND;
        r_ptr   <= w_ptr_nxt;
        r_value <= w_sel.value;
        r_comp  <= w_sel.comp_result;
        r_op    <= w_sel.op;
      end else if (w_free) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // The incoming op.busy is not trusted; the FSM state is the valid flag
  always_comb begin
    w_op_out      = r_op;
    w_op_out.busy = (r_state == ST_SEND);
  end

  assign bus.fu_ready        = w_ready;
  assign bus.value_out       = r_value;
  assign bus.comp_result_out = r_comp;
  assign bus.op_out          = w_op_out;
  assign bus.conflict_cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module : tb_cdb_arbiter
// Brief  : Directed vector bench for cdb_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
  import qu_uop::*;

  typedef struct {
    logic [3:0]  valid;
    logic        rr;
    logic        fl;
    logic [3:0]  rdy;
    logic        busy;
    logic [31:0] val;
    logic [3:0]  rob;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [14];
  logic [31:0] fu_vals [4];

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_FU(4)) bus ();

  cdb_arbiter #(.NUM_FU(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic rr, input logic fl);
    @(negedge clk);
    bus.fu_valid     = v;
    bus.retire_ready = rr;
    bus.flush        = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fu_vals[0] = 32'd15;
    fu_vals[1] = 32'd21;
    fu_vals[2] = 32'd5;
    fu_vals[3] = 32'd40;
    for (int i = 0; i < 4; i++) begin
      bus.fu_result[i].value        = fu_vals[i];
      bus.fu_result[i].comp_result  = i[0];
      bus.fu_result[i].op.busy      = 1'b1;
      bus.fu_result[i].op.rob_addr  = 4'(i + 1);
      bus.fu_result[i].op.opcode    = 6'(i + 7);
      bus.fu_result[i].op.dst_preg  = 6'(i + 20);
    end
    //            valid   rr    fl    rdy     busy  val     rob  cnt
    vecs[0]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 32'd15, 4'd1, 16'd0};
    vecs[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 32'd21, 4'd2, 16'd1};
    vecs[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 32'd5,  4'd3, 16'd2};
    vecs[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 32'd40, 4'd4, 16'd3};
    vecs[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 32'd15, 4'd1, 16'd4};
    vecs[5]  = '{4'b0101, 1'b0, 1'b0, 4'b0000, 1'b1, 32'd15, 4'd1, 16'd5};
    vecs[6]  = '{4'b0101, 1'b0, 1'b0, 4'b0000, 1'b1, 32'd15, 4'd1, 16'd6};
    vecs[7]  = '{4'b0101, 1'b1, 1'b0, 4'b0100, 1'b1, 32'd5,  4'd3, 16'd7};
    vecs[8]  = '{4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 32'd5,  4'd3, 16'd8};
    vecs[9]  = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 32'd15, 4'd1, 16'd9};
    vecs[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'd15, 4'd1, 16'd9};
    vecs[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'd15, 4'd1, 16'd9};
    vecs[12] = '{4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 32'd40, 4'd4, 16'd10};
    vecs[13] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'd40, 4'd4, 16'd10};

    // Reset state, with requests present to show fu_ready is held low
    bus.fu_valid     = 4'b1111;
    bus.retire_ready = 1'b1;
    bus.flush        = 1'b0;
    #12;
    chk("rst_fu_ready", bus.fu_ready, 4'b0000);
    chk("rst_op_out", bus.op_out, '0);
    chk("rst_value", bus.value_out, 32'd0);
    chk("rst_comp", bus.comp_result_out, 1'b0);
    chk("rst_cnt", bus.conflict_cnt, 16'd0);
    bus.fu_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].valid, vecs[i].rr, vecs[i].fl);
      chk($sformatf("v%0d_fu_ready", i), bus.fu_ready, vecs[i].rdy);
      tick();
      chk($sformatf("v%0d_busy", i), bus.op_out.busy, vecs[i].busy);
      chk($sformatf("v%0d_value", i), bus.value_out, vecs[i].val);
      chk($sformatf("v%0d_rob", i), bus.op_out.rob_addr, vecs[i].rob);
      chk($sformatf("v%0d_cnt", i), bus.conflict_cnt, vecs[i].cnt);
    end

    // Backpressure: hold FU2's value 5 for three stalled cycles
    step(4'b0100, 1'b1, 1'b0);
    chk("bp_grant_fu2", bus.fu_ready, 4'b0100);
    tick();
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 1'b0, 1'b0);
      chk($sformatf("bp%0d_fu_ready", i), bus.fu_ready, 4'b0000);
      tick();
      chk($sformatf("bp%0d_value", i), bus.value_out, 32'd5);
      chk($sformatf("bp%0d_busy", i), bus.op_out.busy, 1'b1);
      chk($sformatf("bp%0d_comp", i), bus.comp_result_out, 1'b0);
    end
    step(4'b0010, 1'b1, 1'b0);
    chk("bp_release_grant", bus.fu_ready, 4'b0010);
    tick();
    chk("bp_release_value", bus.value_out, 32'd21);
    chk("bp_release_comp", bus.comp_result_out, 1'b1);

    // Flush beats retire_ready; FU2 wins the following cycle
    step(4'b0100, 1'b1, 1'b1);
    chk("fl_fu_ready", bus.fu_ready, 4'b0000);
    tick();
    chk("fl_busy", bus.op_out.busy, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    chk("fl_next_grant", bus.fu_ready, 4'b0100);
    tick();
    chk("fl_next_busy", bus.op_out.busy, 1'b1);
    chk("fl_next_value", bus.value_out, 32'd5);

    // Grant FU3 (pointer wraps to 0), then async reset mid-SEND
    step(4'b1000, 1'b1, 1'b0);
    chk("wrap_grant_fu3", bus.fu_ready, 4'b1000);
    tick();
    chk("wrap_value", bus.value_out, 32'd40);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_op_out", bus.op_out, '0);
    chk("arst_value", bus.value_out, 32'd0);
    chk("arst_cnt", bus.conflict_cnt, 16'd0);
    chk("arst_fu_ready", bus.fu_ready, 4'b0000);
    bus.fu_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    step(4'b1010, 1'b1, 1'b0);
    chk("post_rst_grant", bus.fu_ready, 4'b0010);
    tick();
    chk("post_rst_value", bus.value_out, 32'd21);

    // Saturation under sustained two-way contention
    step(4'b0011, 1'b1, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_cnt", bus.conflict_cnt, 16'hFFFF);
    tick();
    chk("sat_hold", bus.conflict_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4, is the number of functional-unit result requesters (2..8).
REQ-002 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: the reset is asynchronous and active-low (0 = reset).
REQ-004 Port fu_valid, input, NUM_FU: bit i set when FU i presents a completed result.
REQ-005 Port fu_result, input, NUM_FU x fu_result_t: per-FU {value, comp_result, op}.
REQ-006 Port fu_ready, output, NUM_FU: one-hot grant; the FU i result transfers in any cycle with fu_valid[i] and fu_ready[i] both high.
REQ-007 Port retire_ready, input, 1: the retire stage accepts the current output this cycle.
REQ-008 Port flush, input, 1: mispredicted_branch from retire; discards the held output.
REQ-009 Port value_out, output, phy_rf_data_t: the result value to retire value_in.
REQ-010 Port comp_result_out, output, 1: the branch compare result to retire comp_result_in.
REQ-011 Port op_out, output, res_st_cell_t: the op to retire op_in; op_out.busy is the output-valid flag.
REQ-012 Port conflict_cnt, output, 16: saturating count of cycles in which at least one valid request was not granted.

Function
REQ-013 The output register is "free" when op_out.busy=0, or when op_out.busy=1 and retire_ready=1.
REQ-014 fu_ready shall be combinational and at most one-hot.
- A grant is issued only when the output register is free, flush=0 and rst=1.
REQ-015 Grant selection is round-robin.
- The search starts at rr_ptr and wraps at NUM_FU-1 back to 0.
- The first i with fu_valid[i]=1 is granted.
REQ-016 On a grant to i, rr_ptr shall become (i+1) mod NUM_FU; otherwise rr_ptr holds.
REQ-017 A granted result appears on value_out/comp_result_out/op_out on the next edge with op_out.busy=1, giving one-cycle latency.
REQ-018 The output shall be driven from registers only, with no combinational path from fu_* to the outputs.
REQ-019 FSM states:
- IDLE: busy=0.
- SEND: busy=1.
REQ-020 FSM transitions:
- IDLE -> SEND on grant.
- SEND -> SEND on retire_ready=1 with a new grant.
- SEND -> IDLE on retire_ready=1 with no grant.
- SEND holds when retire_ready=0.
REQ-021 In SEND with retire_ready=0, all output fields shall remain bit-stable and fu_ready shall be 0.
REQ-022 When flush=1, op_out.busy shall be 0 at the next edge (SEND -> IDLE), value_out and comp_result_out may hold, fu_ready=0 that cycle, and rr_ptr is unchanged.
REQ-023 If flush and retire_ready are both 1, flush wins and nothing is granted.
REQ-024 fu_result.op.busy is ignored for arbitration; fu_valid is authoritative.
REQ-025 conflict_cnt increments by 1 when popcount(fu_valid) > number granted (0 or 1), and saturates at 16'hFFFF.
REQ-026 When no FU is valid and the output is free, the block stays in or enters IDLE and rr_ptr holds.

Reset
REQ-027 While rst=0, the following hold asynchronously:
- op_out=0, value_out=0, comp_result_out=0.
- rr_ptr=0, conflict_cnt=0, state=IDLE, fu_ready=0.
REQ-028 Reset asserted mid-transfer discards the held result; the first grant after release starts from FU 0.

Structure
REQ-029 The following belong in the qu_uop package, alongside res_st_cell_t:
- fu_result_t struct {phy_rf_data_t value; logic comp_result; res_st_cell_t op}.
- The NUM_FU default constant.
REQ-030 The round-robin priority pick is a combinational sub-module rr_arbiter (inputs req and ptr, output one-hot gnt); cdb_arbiter holds all state.

Verification
REQ-031 Single request: fu_valid=0001 with value 15, rob_addr 1, retire_ready=1 -> fu_ready=0001 in the same cycle; op_out.busy=1, value_out=15, rob_addr=1 one cycle later.
REQ-032 Round-robin: fu_valid=1111 held for 4 cycles with retire_ready=1 -> grants 0,1,2,3 in order; conflict_cnt=3 after the first three cycles.
REQ-033 Backpressure: retire_ready=0 for 3 cycles while in SEND with value 5 and fu_valid=0010 -> outputs stable at 5 and fu_ready=0; FU1 is granted in the cycle retire_ready returns to 1.
REQ-034 Flush: flush=1 while in SEND with fu_valid=0100 -> op_out.busy=0 next cycle, no grant in the flush cycle, FU2 granted the following cycle.
REQ-035 Wrap and reset: after a grant to FU3, rr_ptr=0; assert rst=0 mid-SEND -> outputs clear immediately without waiting for clk; after release, fu_valid=1010 grants FU1 first.
REQ-036 Saturation: force 65540 cycles of two-way contention -> conflict_cnt=16'hFFFF and does not wrap.
